inv_sqrt_ctrl: RTL
==================

// Module: inv_sqrt_ctrl
// PURPOSE
//   Sequencer for the inverse-square-root datapath: computes y ~= 1/sqrt(x) for one IEEE-754 single.
//   Seeds y with the magic-constant estimate, then runs ITERATIONS Newton steps y = y*(1.5 - 0.5*x*y*y).
//   Issues every multiply to one shared float multiplier and every subtraction to float_sub_1d5,
//   using start/ready handshakes. Top-level start/float_in/float_out/ready match the datapath units.
// PARAMETERS
//   ITERATIONS  1             Newton steps per operation, legal range 1..7
//   MAGIC       32'h5F3759DF  seed constant; y0 = MAGIC - (x >> 1), integer subtract on raw bits
// PORTS
//   clk         in   1   single clock, all state on rising edge
//   rst         in   1   asynchronous, active-high reset
//   start       in   1   request; sampled only in IDLE/DONE, float_in captured same edge
//   float_in    in   32  operand x, IEEE-754 single
//   float_out   out  32  result 1/sqrt(x); held until next accepted start
//   ready       out  1   level: high from result-valid until next accepted start
//   busy        out  1   high from accepted start until result-valid
//   mul_start   out  1   one-cycle pulse to the multiplier
//   mul_a       out  32  multiplier operand A, stable from mul_start until mul_ready rises
//   mul_b       out  32  multiplier operand B, stable from mul_start until mul_ready rises
//   mul_result  in   32  multiplier product, valid while mul_ready high
//   mul_ready   in   1   multiplier done level; falls after mul_start, rises when result valid
//   sub_start   out  1   one-cycle pulse to float_sub_1d5
//   sub_in      out  32  subtrahend t; the unit returns 1.5 - t
//   sub_out     in   32  difference, valid while sub_ready high
//   sub_ready   in   1   sub unit done level, same rules as mul_ready
// BEHAVIOUR
//   Reset: float_out=0, ready=0, busy=0, mul_start=0, sub_start=0, mul_a=mul_b=sub_in=0.
//     State=IDLE, iter=0.
//   Reset mid-operation aborts at once. Results already in flight in the units are ignored,
//     because the rising-edge detectors are also reset.
//   Completion is detected on the rising edge of mul_ready or sub_ready (registered prev value).
//     A ready level left over from the previous operation never counts as completion.
//   States:
//     IDLE  : start=1 -> CHECK; x <= float_in; ready <= 0; busy <= 1.
//     CHECK : x classified, one cycle.
//             sign=1 and x != -0            -> float_out=32'h7FC00000 (NaN), DONE
//             x = +/-0                      -> float_out=32'h7F800000 (+inf), DONE
//             exp=FF, mant!=0 (NaN)         -> float_out=32'h7FC00000, DONE
//             +inf                          -> float_out=32'h00000000, DONE
//             otherwise y <= MAGIC - (x>>1) -> HALF
//     HALF  : mul x*32'h3F000000 -> xh.
//     SQ    : mul y*y -> t.
//     MULX  : mul xh*t -> t.
//     SUB   : sub_in=t -> t.
//     UPD   : mul y*t -> y; iter+1.
//             iter==ITERATIONS -> float_out <= y, DONE; else -> SQ.
//   Each op state has two phases. Issue phase: operands driven and start pulsed for exactly
//     1 cycle. Wait phase: operands held until the unit's ready rises; result latched that edge.
//   DONE: ready=1, busy=0. Stays here until start=1, then -> CHECK directly (same rules as IDLE).
//   start while busy=1 is ignored; no queueing.
//   Totals per normal operation:
//     mul_start pulses = 1 + 3*ITERATIONS; sub_start pulses = ITERATIONS.
//     mul_start and sub_start never high together; at most one unit in flight.
//   Latency: 2 cycles (CHECK + DONE entry) + sum over ops of (1 issue + unit latency + 1).
//     Special-value results: ready high 2 cycles after the start edge.
// TESTING
//   1) x=32'h40800000 (4.0), ITERATIONS=1
//      -> ready rises once; |float_out - 0.5| < 1e-3; mul_start count 4, sub_start count 1.
//   2) x=32'h3F800000 (1.0), ITERATIONS=2
//      -> |float_out - 1.0| < 1e-5; mul_start count 7, sub_start count 2.
//   3) x=0, then x=32'hBF800000 (-1.0), then x=32'h7F800000 (+inf)
//      -> float_out 7F800000, 7FC00000, 00000000 in turn; ready 2 cycles after each start;
//         no mul_start or sub_start pulses.
//   4) start re-pulsed while busy with a different float_in
//      -> ignored; result still matches the first operand.
//   5) rst asserted while waiting on sub_ready
//      -> all outputs 0 asynchronously; a late sub_ready rise causes no state change;
//         next start with x=4.0 gives the result of case 1.
//   6) Back-to-back: start held high at DONE across 10 vectors of random positive normal x
//      -> each float_out within 2e-3 relative of 1/sqrt(x); ready drops for every new operation.

Source files
------------

// File: rtl/inv_sqrt_ctrl.sv
// rtl/inv_sqrt_ctrl.sv - inverse square root sequencer over a shared float multiplier and 1.5-t unit
// Seeds y from the magic constant, then runs Newton steps y = y*(1.5 - 0.5*x*y*y).
module inv_sqrt_ctrl #(
    parameter int          ITERATIONS = 1,
    parameter logic [31:0] MAGIC      = 32'h5F3759DF
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [31:0] float_in,
    output logic [31:0] float_out,
    output logic        ready,
    output logic        busy,
    output logic        mul_start,
    output logic [31:0] mul_a,
    output logic [31:0] mul_b,
    input  logic [31:0] mul_result,
    input  logic        mul_ready,
    output logic        sub_start,
    output logic [31:0] sub_in,
    input  logic [31:0] sub_out,
    input  logic        sub_ready
);
    localparam logic [31:0] HALF_ONE  = 32'h3F000000;
    localparam logic [31:0] QNAN      = 32'h7FC00000;
    localparam logic [31:0] POS_INF   = 32'h7F800000;
    localparam logic [2:0]  LAST_ITER = 3'(ITERATIONS - 1);

    typedef enum logic [2:0] {IDLE, CHECK, HALF, SQ, MULX, SUB, UPD, DONE} state_t;

    state_t      state;
    logic        waiting;
    logic [31:0] x, xh, y, t;
    logic [2:0]  iter;
    logic        mul_ready_q, sub_ready_q;
    logic        mul_done, sub_done;
    logic        is_special;
    logic [31:0] special_val;

    // Only a rise seen during the wait phase completes an op; a stale high level never does.
    assign mul_done = waiting && mul_ready && !mul_ready_q;
    assign sub_done = waiting && sub_ready && !sub_ready_q;

    always_comb begin
        is_special  = 1'b1;
        special_val = QNAN;
        if (x[30:0] == 31'd0)
            special_val = POS_INF;
        else if (x[31])
            special_val = QNAN;
        else if (x[30:23] == 8'hFF)
            special_val = (x[22:0] != 23'd0) ? QNAN : 32'h0;
        else
            is_special = 1'b0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            waiting     <= 1'b0;
            x           <= '0;
            xh          <= '0;
            y           <= '0;
            t           <= '0;
            iter        <= '0;
            mul_ready_q <= 1'b0;
            sub_ready_q <= 1'b0;
            float_out   <= '0;
            ready       <= 1'b0;
            busy        <= 1'b0;
            mul_start   <= 1'b0;
            mul_a       <= '0;
            mul_b       <= '0;
            sub_start   <= 1'b0;
            sub_in      <= '0;
        end else begin
            mul_ready_q <= mul_ready;
            sub_ready_q <= sub_ready;
            mul_start   <= 1'b0;
            sub_start   <= 1'b0;
            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        x     <= float_in;
                        ready <= 1'b0;
                        busy  <= 1'b1;
                        state <= CHECK;
                    end
                end
                CHECK: begin
                    iter    <= '0;
                    waiting <= 1'b0;
                    if (is_special) begin
                        float_out <= special_val;
                        ready     <= 1'b1;
                        busy      <= 1'b0;
                        state     <= DONE;
                    end else begin
                        y     <= MAGIC - {1'b0, x[31:1]};
                        state <= HALF;
                    end
                end
                HALF: begin
                    if (!waiting) begin
                        mul_a     <= x;
                        mul_b     <= HALF_ONE;
                        mul_start <= 1'b1;
                        waiting   <= 1'b1;
                    end else if (mul_done) begin
                        xh      <= mul_result;
                        waiting <= 1'b0;
                        state   <= SQ;
                    end
                end
                SQ: begin
                    if (!waiting) begin
                        mul_a     <= y;
                        mul_b     <= y;
                        mul_start <= 1'b1;
                        waiting   <= 1'b1;
                    end else if (mul_done) begin
                        t       <= mul_result;
                        waiting <= 1'b0;
                        state   <= MULX;
                    end
                end
                MULX: begin
                    if (!waiting) begin
                        mul_a     <= xh;
                        mul_b     <= t;
                        mul_start <= 1'b1;
                        waiting   <= 1'b1;
                    end else if (mul_done) begin
                        t       <= mul_result;
                        waiting <= 1'b0;
                        state   <= SUB;
                    end
                end
                SUB: begin
                    if (!waiting) begin
                        sub_in    <= t;
                        sub_start <= 1'b1;
                        waiting   <= 1'b1;
                    end else if (sub_done) begin
                        t       <= sub_out;
                        waiting <= 1'b0;
                        state   <= UPD;
                    end
                end
                UPD: begin
                    if (!waiting) begin
                        mul_a     <= y;
                        mul_b     <= t;
                        mul_start <= 1'b1;
                        waiting   <= 1'b1;
                    end else if (mul_done) begin
                        y       <= mul_result;
                        iter    <= iter + 3'd1;
                        waiting <= 1'b0;
                        if (iter == LAST_ITER) begin
                            float_out <= mul_result;
                            ready     <= 1'b1;
                            busy      <= 1'b0;
                            state     <= DONE;
                        end else begin
                            state <= SQ;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
